// File: rtl/shift_add_mul4_ctrl.sv
// Sequential 4x4 unsigned shift-add multiplier.
// A single 4-bit ripple-carry adder is reused for every partial-product
// addition; operands arrive over a valid/ready handshake and the 8-bit
// product leaves over a second valid/ready handshake.

module rca_4b1 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [4:0] carry_s;

    // Ripple the carry bit by bit through four full adders.
    always_comb begin
        carry_s    = 5'b0_0000;
        sum        = 4'b0000;
        carry_s[0] = cin;
        for (int i = 0; i < 4; i++) begin
            sum[i]         = a[i] ^ b[i] ^ carry_s[i];
            carry_s[i + 1] = (a[i] & b[i]) | (carry_s[i] & (a[i] ^ b[i]));
        end
        cout = carry_s[4];
    end

endmodule

module shift_add_mul4_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] product,
    output logic       busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t     state_r;
    logic [3:0] m_r;          // multiplicand
    logic [7:0] p_r;          // {accumulator, remaining multiplier bits}
    logic [1:0] cnt_r;        // CALC step index
    logic [7:0] product_r;
    logic       in_ready_r;
    logic       out_valid_r;
    logic       busy_r;

    logic [3:0] sum_s;
    logic       cout_s;
    logic [7:0] p_next_s;

    // The only adder in the block: accumulator plus multiplicand.
    rca_4b1 u_rca (
        .a    (p_r[7:4]),
        .b    (m_r),
        .cin  (1'b0),
        .sum  (sum_s),
        .cout (cout_s)
    );

    // One shift-add step: add when the current multiplier LSB is set, then
    // shift right; the adder carry lands in P[7] so nothing is ever lost.
    always_comb begin
        p_next_s = 8'h00;
        if (p_r[0]) begin
            p_next_s = {cout_s, sum_s, p_r[3:1]};
        end else begin
            p_next_s = {1'b0, p_r[7:1]};
        end
    end

    // Control FSM with datapath registers; status flags are registered
    // alongside the state so they always equal a decode of it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            m_r         <= 4'h0;
            p_r         <= 8'h00;
            cnt_r       <= 2'd0;
            product_r   <= 8'h00;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        m_r        <= a;
                        p_r        <= {4'h0, b};
                        cnt_r      <= 2'd0;
                        state_r    <= ST_CALC;
                        in_ready_r <= 1'b0;
                        busy_r     <= 1'b1;
                    end else begin
                        state_r    <= ST_IDLE;
                    end
                end
                ST_CALC: begin
                    p_r   <= p_next_s;
                    cnt_r <= cnt_r + 2'd1;
                    if (cnt_r == 2'd3) begin
                        // Capture the post-shift value of the final step.
                        product_r   <= p_next_s;
                        state_r     <= ST_DONE;
                        out_valid_r <= 1'b1;
                    end else begin
                        state_r     <= ST_CALC;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_r     <= ST_IDLE;
                        out_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                        in_ready_r  <= 1'b1;
                    end else begin
                        state_r     <= ST_DONE;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    cnt_r       <= 2'd0;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign product   = product_r;

endmodule
